decode_stage: RTL and testbench

//  Y86-64 pipeline stage directly downstream of fetch: holds the F->D pipeline register
//  (D_*), decodes register IDs, and reads the 15-entry register file.

---
 rtl/y86_defs.sv | 36 +++
 rtl/decode_stage_regfile.sv | 44 ++++
 rtl/decode_stage.sv | 157 +++++++++++++++
 tb/tb_decode_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_defs.sv
// Shared Y86-64 definitions: instruction codes, register IDs, status codes and
// the opcode injected when a pipeline register is bubbled.
package y86_defs;

    // Instruction codes (upper nibble of the opcode byte)
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Register file geometry and special IDs
    localparam int         NREG   = 15;
    localparam logic [3:0] RNONE  = 4'hF;
    localparam logic [3:0] RSP_ID = 4'h4;

    // Bubble contents
    localparam logic [7:0] NOP_OP   = 8'h10;
    localparam logic [7:0] NOP_RARB = 8'hFF;

    // Instruction status carried down the pipe
    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_t;

endpackage

// File: rtl/decode_stage_regfile.sv
// 15 x 64-bit architectural register file. Two asynchronous read ports, two
// synchronous write ports (E and M), synchronous clear. ID F reads as zero and
// is never written. When both write ports target the same register, port M
// wins so that popq %rsp leaves the loaded value in %rsp.
module decode_stage_regfile
    import y86_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  raddr_a,
    input  logic [3:0]  raddr_b,
    output logic [63:0] rdata_a,
    output logic [63:0] rdata_b,
    input  logic [3:0]  waddr_e,
    input  logic [63:0] wdata_e,
    input  logic [3:0]  waddr_m,
    input  logic [63:0] wdata_m
);

    logic [63:0] regs [NREG];

    // Clear on reset, otherwise apply port E then port M so M takes precedence
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 64'd0;
            end
        end else begin
            if (waddr_e != RNONE) begin
                regs[waddr_e] <= wdata_e;
            end
            if (waddr_m != RNONE) begin
                regs[waddr_m] <= wdata_m;
            end
        end
    end

    // Asynchronous reads; same-cycle writes are not visible until the next cycle
    always_comb begin
        rdata_a = (raddr_a == RNONE) ? 64'd0 : regs[raddr_a];
        rdata_b = (raddr_b == RNONE) ? 64'd0 : regs[raddr_b];
    end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: F->D pipeline register, register-ID decode, register
// file read/writeback and valA/valB forwarding from the e, M and W stages.
// Pipeline control: D_stall holds the D register and has priority over
// D_bubble, which replaces the D contents with a nop. Neither touches the
// register file.
module decode_stage
    import y86_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  f_opcode,
    input  logic [7:0]  f_rArB,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic [1:0]  f_stat,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstE,
    input  logic [63:0] M_valE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] m_valM,
    input  logic [3:0]  W_dstE,
    input  logic [63:0] W_valE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valM,
    output logic [7:0]  D_opcode,
    output logic [7:0]  D_rArB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP,
    output logic [1:0]  D_stat,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [3:0]  d_dstE,
    output logic [3:0]  d_dstM,
    output logic [63:0] d_valA,
    output logic [63:0] d_valB
);

    logic [3:0]  icode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] rf_a;
    logic [63:0] rf_b;

    // D pipeline register: reset, then stall, then bubble, then load
    always_ff @(posedge clk) begin
        if (rst) begin
            D_opcode <= NOP_OP;
            D_rArB   <= NOP_RARB;
            D_valC   <= 64'd0;
            D_valP   <= 64'd0;
            D_stat   <= STAT_AOK;
        end else if (D_stall) begin
            D_opcode <= D_opcode;
            D_rArB   <= D_rArB;
            D_valC   <= D_valC;
            D_valP   <= D_valP;
            D_stat   <= D_stat;
        end else if (D_bubble) begin
            D_opcode <= NOP_OP;
            D_rArB   <= NOP_RARB;
            D_valC   <= 64'd0;
            D_valP   <= 64'd0;
            D_stat   <= STAT_AOK;
        end else begin
            D_opcode <= f_opcode;
            D_rArB   <= f_rArB;
            D_valC   <= f_valC;
            D_valP   <= f_valP;
            D_stat   <= f_stat;
        end
    end

    assign icode = D_opcode[7:4];
    assign ra    = D_rArB[7:4];
    assign rb    = D_rArB[3:0];

    // Register-ID decode; a faulted instruction names no registers at all
    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        if (D_stat == STAT_AOK) begin
            case (icode)
                I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = ra;
                I_RET, I_POPQ:                      d_srcA = RSP_ID;
                default:                            d_srcA = RNONE;
            endcase
            case (icode)
                I_RMMOVQ, I_MRMOVQ, I_OPQ:          d_srcB = rb;
                I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_srcB = RSP_ID;
                default:                            d_srcB = RNONE;
            endcase
            // cmov (rrmovq) always names rB here; execute cancels it if the condition fails
            case (icode)
                I_RRMOVQ, I_IRMOVQ, I_OPQ:          d_dstE = rb;
                I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_dstE = RSP_ID;
                I_HALT, I_NOP:                      d_dstE = RNONE;
                default:                            d_dstE = RNONE;
            endcase
            case (icode)
                I_MRMOVQ, I_POPQ:                   d_dstM = ra;
                default:                            d_dstM = RNONE;
            endcase
        end
    end

    decode_stage_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (d_srcA),
        .raddr_b (d_srcB),
        .rdata_a (rf_a),
        .rdata_b (rf_b),
        .waddr_e (W_dstE),
        .wdata_e (W_valE),
        .waddr_m (W_dstM),
        .wdata_m (W_valM)
    );

    // Operand selection: youngest producer wins; jXX/call carry valP in valA
    always_comb begin
        if (icode == I_JXX || icode == I_CALL) begin
            d_valA = D_valP;
        end else if (d_srcA != RNONE && d_srcA == e_dstE) begin
            d_valA = e_valE;
        end else if (d_srcA != RNONE && d_srcA == M_dstM) begin
            d_valA = m_valM;
        end else if (d_srcA != RNONE && d_srcA == M_dstE) begin
            d_valA = M_valE;
        end else if (d_srcA != RNONE && d_srcA == W_dstM) begin
            d_valA = W_valM;
        end else if (d_srcA != RNONE && d_srcA == W_dstE) begin
            d_valA = W_valE;
        end else begin
            d_valA = rf_a;
        end

        if (d_srcB != RNONE && d_srcB == e_dstE) begin
            d_valB = e_valE;
        end else if (d_srcB != RNONE && d_srcB == M_dstM) begin
            d_valB = m_valM;
        end else if (d_srcB != RNONE && d_srcB == M_dstE) begin
            d_valB = M_valE;
        end else if (d_srcB != RNONE && d_srcB == W_dstM) begin
            d_valB = W_valM;
        end else if (d_srcB != RNONE && d_srcB == W_dstE) begin
            d_valB = W_valE;
        end else begin
            d_valB = rf_b;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  f_opcode, f_rArB;
    logic [63:0] f_valC, f_valP;
    logic [1:0]  f_stat;
    logic        D_stall, D_bubble;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [7:0]  D_opcode, D_rArB;
    logic [63:0] D_valC, D_valP;
    logic [1:0]  D_stat;
    logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
    logic [63:0] d_valA, d_valB;

    int total = 0;
    int bad   = 0;
    logic check_en = 1'b0;

    // Behavioural model state: D register fields and 16 register slots (slot 15 stays 0)
    logic [7:0]  m_op, m_rarb;
    logic [63:0] m_valc, m_valp;
    logic [1:0]  m_stat;
    logic [63:0] m_rf [16];

    decode_stage dut (
        .clk(clk), .rst(rst),
        .f_opcode(f_opcode), .f_rArB(f_rArB), .f_valC(f_valC), .f_valP(f_valP), .f_stat(f_stat),
        .D_stall(D_stall), .D_bubble(D_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_valE(M_valE),
        .M_dstM(M_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM),
        .D_opcode(D_opcode), .D_rArB(D_rArB), .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_valA(d_valA), .d_valB(d_valB)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic [3:0] m_icode();
        return m_op[7:4];
    endfunction

    function automatic logic [3:0] exp_src_a();
        logic [3:0] ic = m_op[7:4];
        if (m_stat != 2'd0) return 4'hF;
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return m_rarb[7:4];
        if (ic inside {4'h9, 4'hB}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] exp_src_b();
        logic [3:0] ic = m_op[7:4];
        if (m_stat != 2'd0) return 4'hF;
        if (ic inside {4'h4, 4'h5, 4'h6}) return m_rarb[3:0];
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] exp_dst_e();
        logic [3:0] ic = m_op[7:4];
        if (m_stat != 2'd0) return 4'hF;
        if (ic inside {4'h2, 4'h3, 4'h6}) return m_rarb[3:0];
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] exp_dst_m();
        logic [3:0] ic = m_op[7:4];
        if (m_stat != 2'd0) return 4'hF;
        if (ic inside {4'h5, 4'hB}) return m_rarb[7:4];
        return 4'hF;
    endfunction

    // Value of register id as seen by decode this cycle, youngest producer first
    function automatic logic [63:0] operand(input logic [3:0] id);
        logic [3:0]  ids  [5];
        logic [63:0] vals [5];
        ids[0] = e_dstE; vals[0] = e_valE;
        ids[1] = M_dstM; vals[1] = m_valM;
        ids[2] = M_dstE; vals[2] = M_valE;
        ids[3] = W_dstM; vals[3] = W_valM;
        ids[4] = W_dstE; vals[4] = W_valE;
        if (id == 4'hF) return 64'd0;
        for (int k = 0; k < 5; k++) begin
            if (ids[k] == id) return vals[k];
        end
        return m_rf[id];
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        if (rst) begin
            m_op = 8'h10; m_rarb = 8'hFF; m_valc = 0; m_valp = 0; m_stat = 0;
            for (int k = 0; k < 16; k++) m_rf[k] = 64'd0;
        end else begin
            if (!D_stall) begin
                if (D_bubble) begin
                    m_op = 8'h10; m_rarb = 8'hFF; m_valc = 0; m_valp = 0; m_stat = 0;
                end else begin
                    m_op = f_opcode; m_rarb = f_rArB; m_valc = f_valC; m_valp = f_valP; m_stat = f_stat;
                end
            end
            if (W_dstE != 4'hF) m_rf[W_dstE] = W_valE;
            if (W_dstM != 4'hF) m_rf[W_dstM] = W_valM;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Compare every output against the model, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            chk("D_opcode", {56'd0, D_opcode}, {56'd0, m_op});
            chk("D_rArB",   {56'd0, D_rArB},   {56'd0, m_rarb});
            chk("D_valC",   D_valC,            m_valc);
            chk("D_valP",   D_valP,            m_valp);
            chk("D_stat",   {62'd0, D_stat},   {62'd0, m_stat});
            chk("d_srcA",   {60'd0, d_srcA},   {60'd0, exp_src_a()});
            chk("d_srcB",   {60'd0, d_srcB},   {60'd0, exp_src_b()});
            chk("d_dstE",   {60'd0, d_dstE},   {60'd0, exp_dst_e()});
            chk("d_dstM",   {60'd0, d_dstM},   {60'd0, exp_dst_m()});
            chk("d_valA",   d_valA,
                (m_icode() == 4'h7 || m_icode() == 4'h8) ? m_valp : operand(exp_src_a()));
            chk("d_valB",   d_valB,            operand(exp_src_b()));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic clear_fwd();
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
        e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
    endtask

    function automatic logic [3:0] rand_dst();
        logic [3:0] r = 4'($urandom_range(0, 14));
        return ($urandom_range(0, 2) == 0) ? 4'hF : r;
    endfunction

    task automatic randomize_inputs();
        f_opcode = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 6))};
        f_rArB   = 8'($urandom);
        f_valC   = {$urandom, $urandom};
        f_valP   = {$urandom, $urandom};
        f_stat   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        D_stall  = ($urandom_range(0, 7) == 0);
        D_bubble = ($urandom_range(0, 7) == 0);
        rst      = ($urandom_range(0, 99) == 0);
        e_dstE = rand_dst(); e_valE = {$urandom, $urandom};
        M_dstE = rand_dst(); M_valE = {$urandom, $urandom};
        M_dstM = rand_dst(); m_valM = {$urandom, $urandom};
        W_dstE = rand_dst(); W_valE = {$urandom, $urandom};
        W_dstM = rand_dst(); W_valM = {$urandom, $urandom};
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; D_stall = 1'b0; D_bubble = 1'b0;
        f_opcode = 8'h00; f_rArB = 8'h00; f_valC = 0; f_valP = 0; f_stat = 0;
        clear_fwd();

        // Reset
        tick();
        rst = 1'b0;
        check_en = 1'b1;
        #1;
        chk("rst_opcode", {56'd0, D_opcode}, 64'h10);
        chk("rst_stat",   {62'd0, D_stat},   64'd0);
        chk("rst_srcA",   {60'd0, d_srcA},   64'hF);
        chk("rst_srcB",   {60'd0, d_srcB},   64'hF);
        chk("rst_dstE",   {60'd0, d_dstE},   64'hF);
        chk("rst_dstM",   {60'd0, d_dstM},   64'hF);

        // addq %r2,%r3 while r2=5, r3=7 are written through the W ports
        W_dstE = 4'd2; W_valE = 64'd5; W_dstM = 4'd3; W_valM = 64'd7;
        f_opcode = 8'h60; f_rArB = 8'h23;
        tick();
        clear_fwd();
        #1;
        chk("add_srcA", {60'd0, d_srcA}, 64'd2);
        chk("add_srcB", {60'd0, d_srcB}, 64'd3);
        chk("add_dstE", {60'd0, d_dstE}, 64'd3);
        chk("add_valA", d_valA, 64'd5);
        chk("add_valB", d_valB, 64'd7);

        // e beats M when both forward r2
        D_stall = 1'b1;
        e_dstE = 4'd2; e_valE = 64'd99; M_dstE = 4'd2; M_valE = 64'd11;
        #1;
        chk("fwd_e_over_m", d_valA, 64'd99);
        D_stall = 1'b0;
        clear_fwd();

        // Both W ports hit r4: the M port value lands
        W_dstE = 4'd4; W_valE = 64'd100; W_dstM = 4'd4; W_valM = 64'd200;
        f_opcode = 8'h20; f_rArB = 8'h4F;
        tick();
        clear_fwd();
        #1;
        chk("wm_wins_src", {60'd0, d_srcA}, 64'd4);
        chk("wm_wins_val", d_valA, 64'd200);

        // Stall, stall+bubble, bubble
        D_stall = 1'b1; f_opcode = 8'h30;
        tick();
        chk("stall_hold", {56'd0, D_opcode}, 64'h20);
        D_bubble = 1'b1;
        tick();
        chk("stall_beats_bubble", {56'd0, D_opcode}, 64'h20);
        D_stall = 1'b0;
        tick();
        chk("bubble_op",   {56'd0, D_opcode}, 64'h10);
        chk("bubble_rarb", {56'd0, D_rArB},   64'hFF);
        D_bubble = 1'b0;

        // call carries valP; a faulted fetch names no registers
        f_opcode = 8'h80; f_rArB = 8'hFF; f_valP = 64'h20;
        tick();
        chk("call_valA", d_valA, 64'h20);
        chk("call_srcB", {60'd0, d_srcB}, 64'd4);
        chk("call_dstE", {60'd0, d_dstE}, 64'd4);
        f_opcode = 8'h60; f_rArB = 8'h23; f_stat = 2'd3;
        tick();
        chk("ins_srcA", {60'd0, d_srcA}, 64'hF);
        chk("ins_srcB", {60'd0, d_srcB}, 64'hF);
        chk("ins_dstE", {60'd0, d_dstE}, 64'hF);
        chk("ins_dstM", {60'd0, d_dstM}, 64'hF);
        f_stat = 2'd0;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            tick();
        end

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
